// File: rtl/win_mul_arbiter_if.sv
// Requester and multiplier signal bundle for win_mul_arbiter.
// slave = the arbiter itself; master = the surrounding datapath / multiplier.
interface win_mul_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [8*NUM_REQ-1:0] req_a;
  logic [8*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [15:0]          rsp_data;
  logic                 rsp_err;
  logic                 busy;
  logic [7:0]           mul_a;
  logic [7:0]           mul_b;
  logic                 mul_start;
  logic [15:0]          mul_result;
  logic                 mul_done;

  modport slave (
    input  req_valid, req_a, req_b, mul_result, mul_done,
    output req_ready, rsp_valid, rsp_data, rsp_err, busy, mul_a, mul_b, mul_start
  );

  modport master (
    output req_valid, req_a, req_b, mul_result, mul_done,
    input  req_ready, rsp_valid, rsp_data, rsp_err, busy, mul_a, mul_b, mul_start
  );
endinterface

// File: rtl/win_mul_arbiter.sv
// Round-robin sequencer sharing one multi-cycle 8x8 multiplier; accept->rsp_valid is 2 cycles (zero bypass) or 3+k.
// req_ready only in IDLE with one transaction in flight; responses have no backpressure, a hung multiplier times out.
module win_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16,
  parameter int GW      = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  win_mul_arbiter_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_BYPASS,
    S_RESP
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [GW-1:0]        r_last_grant;
  logic [GW-1:0]        r_grant;
  logic [GW-1:0]        w_win;
  logic                 w_any;
  logic [7:0]           r_op_a;
  logic [7:0]           r_op_b;
  logic [7:0]           w_in_a;
  logic [7:0]           w_in_b;
  logic [CW-1:0]        r_cnt;
  logic                 w_timeout;
  logic [15:0]          r_rsp_data;
  logic                 r_rsp_err;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [NUM_REQ-1:0]   w_ready;
  logic                 w_mul_en;

  function automatic logic [GW-1:0] f_rr_idx(input logic [GW-1:0] base, input int off);
    return GW'((int'(base) + off) % NUM_REQ);
  endfunction

  // First valid requester strictly after last_grant, wrapping around.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!w_any && bus.req_valid[f_rr_idx(r_last_grant, i)]) begin
        w_any = 1'b1;
        w_win = f_rr_idx(r_last_grant, i);
      end
    end
  end

  assign w_in_a    = bus.req_a[8*w_win +: 8];
  assign w_in_b    = bus.req_b[8*w_win +: 8];
  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_ready[w_win] = 1'b1;
          // Sign bit ignored: +0 and -0 both skip the multiplier.
          if (w_in_a[6:0] == 7'd0 || w_in_b[6:0] == 7'd0) begin
            w_state_nxt = S_BYPASS;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE:  w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.mul_done || w_timeout) begin
          w_state_nxt = S_RESP;
        end
      end
      S_BYPASS: w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= GW'(NUM_REQ - 1);
      r_grant      <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_cnt        <= '0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
      r_rsp_valid  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_op_a  <= w_in_a;
            r_op_b  <= w_in_b;
            r_grant <= w_win;
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // A done arriving on the timeout cycle still delivers its product.
          if (bus.mul_done) begin
            r_rsp_data <= bus.mul_result;
            r_rsp_err  <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
          end
        end
        S_BYPASS: begin
          r_rsp_data <= '0;
          r_rsp_err  <= 1'b0;
        end
        S_RESP:  r_last_grant <= r_grant;
        default: ;
      endcase
      r_rsp_valid <= '0;
      if (w_state_nxt == S_RESP) begin
        r_rsp_valid[r_grant] <= 1'b1;
      end
    end
  end

  assign w_mul_en      = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.mul_a     = w_mul_en ? r_op_a : 8'h00;
  assign bus.mul_b     = w_mul_en ? r_op_b : 8'h00;
  assign bus.mul_start = (r_state == S_ISSUE);

endmodule

// File: tb/tb_win_mul_arbiter.sv
// Directed bench for win_mul_arbiter: vector table of single transactions plus
// hand sequences for round-robin order and reset while waiting on the multiplier.
module tb_win_mul_arbiter;

  localparam int NR = 4;

  logic clk;
  logic rst_n;

  win_mul_arbiter_if #(.NUM_REQ(NR)) bus ();

  win_mul_arbiter #(.NUM_REQ(NR), .TIMEOUT(16), .GW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          req;
    logic [7:0]  a;
    logic [7:0]  b;
    int          k;
    logic [15:0] res;
    int          lat;
    logic [15:0] data;
    logic        err;
    bit          normal;
    bit          stray;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Multiplier model: done rises k edges after the edge that sampled mul_start; k=0 never answers.
  logic        mdl_done;
  logic        extra_done;
  logic        mdl_st;
  logic [15:0] mdl_res;
  int          mdl_k;
  int          mdl_cnt;

  assign bus.mul_done   = mdl_done | extra_done;
  assign bus.mul_result = mdl_res;

  initial begin
    mdl_done = 1'b0;
    mdl_cnt  = 0;
    forever begin
      @(negedge clk);
      mdl_st = bus.mul_start;
      @(posedge clk);
      #1;
      mdl_done = 1'b0;
      if (mdl_st) begin
        mdl_cnt = mdl_k;
      end else if (mdl_cnt > 0) begin
        mdl_cnt--;
        if (mdl_cnt == 0) mdl_done = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  function automatic int oh_idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic do_reset();
    adv();
    rst_n = 1'b0;
    #20;
    rst_n = 1'b1;
  endtask

  task automatic do_txn(input vec_t v, input int id);
    int          lat;
    int          starts;
    int          opcyc;
    int          badop;
    bit          got;
    logic [NR-1:0] rv;
    lat = 0; starts = 0; opcyc = 0; badop = 0; got = 1'b0; rv = '0;
    adv();
    bus.req_valid = '0;
    bus.req_valid[v.req] = 1'b1;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_a[8*v.req +: 8] = v.a;
    bus.req_b[8*v.req +: 8] = v.b;
    mdl_k   = v.k;
    mdl_res = v.res;
    @(negedge clk);
    chk($sformatf("v%0d/ready", id), 32'(bus.req_ready), 32'(1 << v.req));
    chk($sformatf("v%0d/idle_busy", id), 32'(bus.busy), 32'd0);
    adv();
    // Operands must only be sampled in the accept cycle.
    bus.req_valid = '0;
    bus.req_a = '1;
    bus.req_b = '1;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (bus.mul_start) starts++;
      if (bus.mul_start || bus.mul_a != 8'h00 || bus.mul_b != 8'h00) begin
        opcyc++;
        if (bus.mul_a !== v.a || bus.mul_b !== v.b) badop++;
      end
      if (bus.rsp_valid != '0) begin
        got = 1'b1;
        lat = c;
        rv  = bus.rsp_valid;
      end else begin
        adv();
      end
    end
    chk($sformatf("v%0d/latency", id), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d/rsp_valid", id), 32'(rv), 32'(1 << v.req));
    chk($sformatf("v%0d/rsp_data", id), 32'(bus.rsp_data), 32'(v.data));
    chk($sformatf("v%0d/rsp_err", id), 32'(bus.rsp_err), 32'(v.err));
    chk($sformatf("v%0d/starts", id), 32'(starts), v.normal ? 32'd1 : 32'd0);
    chk($sformatf("v%0d/op_cycles", id), 32'(opcyc), v.normal ? 32'(v.lat - 1) : 32'd0);
    chk($sformatf("v%0d/op_stable", id), 32'(badop), 32'd0);
    if (v.stray) begin
      extra_done = 1'b1;
      mdl_res    = 16'hDEAD;
    end
    adv();
    @(negedge clk);
    chk($sformatf("v%0d/rsp_one_cycle", id), 32'(bus.rsp_valid), 32'd0);
    chk($sformatf("v%0d/busy_after", id), 32'(bus.busy), 32'd0);
    chk($sformatf("v%0d/data_hold", id), 32'(bus.rsp_data), 32'(v.data));
    adv();
    extra_done = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d/idle_hold_busy", id), 32'(bus.busy), 32'd0);
    chk($sformatf("v%0d/idle_hold_data", id), 32'(bus.rsp_data), 32'(v.data));
    chk($sformatf("v%0d/idle_hold_err", id), 32'(bus.rsp_err), 32'(v.err));
  endtask

  int acc_q[$];
  int rsp_q[$];
  int multi;

  // Records accept and response order until n responses have been seen.
  task automatic collect(input int n);
    acc_q.delete();
    rsp_q.delete();
    multi = 0;
    for (int c = 0; c < 300 && rsp_q.size() < n; c++) begin
      @(negedge clk);
      if ($countones(bus.req_ready) > 1) multi++;
      if (bus.req_ready != '0) acc_q.push_back(oh_idx(bus.req_ready));
      if (bus.rsp_valid != '0) rsp_q.push_back(oh_idx(bus.rsp_valid));
      adv();
    end
    bus.req_valid = '0;
  endtask

  vec_t tbl [9];
  int   exp_ord [6];

  initial begin
    tbl[0] = '{0, 8'h03, 8'h05,  2, 16'h000F,  5, 16'h000F, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{2, 8'h80, 8'h7F,  0, 16'hBEEF,  2, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1, 8'h12, 8'h00,  0, 16'hBEEF,  2, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{3, 8'h85, 8'h02,  1, 16'h800A,  4, 16'h800A, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1, 8'h11, 8'h22,  0, 16'h1111, 18, 16'h0000, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1, 8'h07, 8'h06,  3, 16'h002A,  6, 16'h002A, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{0, 8'h7F, 8'h7F, 15, 16'h3F01, 18, 16'h3F01, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{2, 8'h09, 8'h09, 14, 16'h0051, 17, 16'h0051, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{3, 8'h00, 8'h55,  0, 16'hBEEF,  2, 16'h0000, 1'b0, 1'b0, 1'b0};
    exp_ord = '{0, 1, 2, 3, 0, 1};

    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    extra_done    = 1'b0;
    mdl_res       = 16'h0000;
    mdl_k         = 0;
    #2;
    chk("rst/req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst/rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rst/rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst/busy", 32'(bus.busy), 32'd0);
    chk("rst/mul_a", 32'(bus.mul_a), 32'd0);
    chk("rst/mul_b", 32'(bus.mul_b), 32'd0);
    chk("rst/mul_start", 32'(bus.mul_start), 32'd0);
    adv();
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      do_txn(tbl[i], i);
    end

    // All four requesters held valid from reset: strict rotation starting at 0.
    do_reset();
    bus.req_valid = 4'hF;
    bus.req_a     = {8'h04, 8'h03, 8'h02, 8'h01};
    bus.req_b     = {8'h03, 8'h03, 8'h03, 8'h03};
    mdl_k         = 1;
    mdl_res       = 16'h0055;
    collect(6);
    chk("rr/multi_ready", 32'(multi), 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr/accept%0d", i), 32'(i < acc_q.size() ? acc_q[i] : -1), 32'(exp_ord[i]));
      chk($sformatf("rr/rsp%0d", i), 32'(i < rsp_q.size() ? rsp_q[i] : -1), 32'(exp_ord[i]));
    end

    // Reset while the multiplier is outstanding.
    adv();
    bus.req_valid = 4'b0100;
    bus.req_a     = {8'h00, 8'h05, 8'h00, 8'h00};
    bus.req_b     = {8'h00, 8'h05, 8'h00, 8'h00};
    mdl_k         = 0;
    @(negedge clk);
    chk("rw/ready", 32'(bus.req_ready), 32'h4);
    adv();
    bus.req_valid = '0;
    adv();
    adv();
    chk("rw/in_wait_busy", 32'(bus.busy), 32'd1);
    chk("rw/in_wait_mul_a", 32'(bus.mul_a), 32'h05);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw/busy", 32'(bus.busy), 32'd0);
    chk("rw/mul_a", 32'(bus.mul_a), 32'd0);
    chk("rw/mul_b", 32'(bus.mul_b), 32'd0);
    chk("rw/rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rw/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    bus.req_valid = 4'b0011;
    bus.req_a     = {8'h00, 8'h00, 8'h02, 8'h03};
    bus.req_b     = {8'h00, 8'h00, 8'h04, 8'h04};
    mdl_k         = 1;
    mdl_res       = 16'h1234;
    #10;
    rst_n = 1'b1;
    collect(2);
    chk("rw/first_grant", 32'(acc_q.size() > 0 ? acc_q[0] : -1), 32'd0);
    chk("rw/second_grant", 32'(acc_q.size() > 1 ? acc_q[1] : -1), 32'd1);
    chk("rw/first_rsp", 32'(rsp_q.size() > 0 ? rsp_q[0] : -1), 32'd0);
    chk("rw/rsp_data", 32'(bus.rsp_data), 32'h1234);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/win_mul_arbiter.md
Name: win_mul_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one multi-cycle 8x8 sign-magnitude multiplier among NUM_REQ requesters in the Winograd LeNet datapath.
- Accepts operand pairs over per-requester valid/ready handshakes and sequences start/done with the shared multiplier.
- Bypasses the multiplier when either operand is zero; returns each result to the originating requester.
- Includes a done-watchdog so a hung multiplier cannot stall the array.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT, 16, max WAIT cycles before an error response (>=2)
- GW, 2, grant index width, equals clog2(NUM_REQ)

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  NUM_REQ  per-requester operand valid
- req_ready  output  NUM_REQ  one-hot accept (combinational)
- req_a  input  8*NUM_REQ  packed sign-magnitude operand A; requester i at [8i+7:8i]
- req_b  input  8*NUM_REQ  packed sign-magnitude operand B
- rsp_valid  output  NUM_REQ  one-hot, one-cycle response strobe (registered)
- rsp_data  output  16  product, shared by all requesters; valid only with rsp_valid
- rsp_err  output  1  timeout flag, qualified by rsp_valid
- busy  output  1  high in every state except IDLE
- mul_a  output  8  operand A to multiplier
- mul_b  output  8  operand B to multiplier
- mul_start  output  1  one-cycle launch pulse
- mul_result  input  16  multiplier product
- mul_done  input  1  one-cycle product-valid pulse

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; last_grant = NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, ISSUE, WAIT, BYPASS, RESP. The FSM advances every cycle except in IDLE with no request and in WAIT.
- IDLE, arbitration:
  - If any req_valid is high, the winner is the first set bit searching from last_grant+1 upward with wrap-around.
  - req_ready[winner]=1 in that same cycle; all other req_ready bits stay 0.
  - req_ready is 0 in all states other than IDLE.
- IDLE, accept:
  - On accept, latch operands into op_a/op_b and the winner into grant.
  - Next state is BYPASS if op_a[6:0]==0 or op_b[6:0]==0; positive and negative zero both qualify. Otherwise next state is ISSUE.
- ISSUE:
  - mul_start=1 for exactly this cycle; clear the wait counter.
  - Next state is WAIT.
- mul_a/mul_b: driven from op_a/op_b in ISSUE and WAIT, and held stable until exit from WAIT; 0 otherwise.
- WAIT:
  - Increment the counter each cycle.
  - If mul_done=1, capture mul_result into rsp_data with rsp_err=0, then go to RESP.
  - Else, if counter==TIMEOUT-1, set rsp_data=0 and rsp_err=1, then go to RESP.
  - If mul_done and the timeout coincide, mul_done wins.
- BYPASS: rsp_data=16'h0000, rsp_err=0; next state is RESP.
- RESP:
  - rsp_valid[grant]=1 for exactly one cycle; no backpressure, so requesters must sink it.
  - Set last_grant=grant; next state is IDLE.
  - rsp_data/rsp_err hold their values until the next capture.
- Latency from accept cycle to rsp_valid:
  - bypass: 2 cycles;
  - normal: 3+k cycles, where mul_done arrives k cycles after mul_start (k>=1).
- Throughput: at most one transaction in flight; the next accept can occur in the cycle after RESP.
- Data handling: operands and result pass through unmodified; the sign-magnitude vs two's-complement interpretation belongs to the multiplier and consumer.
- mul_done outside WAIT is ignored and is not latched.
- Requester dropping req_valid before acceptance: legal, and the request is simply not seen.
- req_a/req_b: sampled only in the accept cycle.
- Reset mid-operation: immediate return to reset values. The in-flight transaction is dropped with no rsp_valid, and priority restarts at requester 0.

Test Plan:
- Single transaction:
  - Stimulus: req 0 with a=8'h03, b=8'h05; model returns 16'h000F two cycles after start.
  - Response: exactly one mul_start; mul_a/mul_b stable through WAIT; rsp_valid=4'b0001 for one cycle; rsp_data=16'h000F; rsp_err=0; latency 5 cycles.
- Round-robin fairness:
  - Stimulus: all four req_valid held high continuously.
  - Response: accept order 0,1,2,3,0,1; never two req_ready bits in one cycle; rsp_valid one-hot matches accept order.
- Zero bypass:
  - Stimulus: req 2 with a=8'h80 (negative zero), b=8'h7F.
  - Response: no mul_start; rsp_valid=4'b0100 two cycles after accept; rsp_data=16'h0000.
- Watchdog:
  - Stimulus: TIMEOUT=16; model never asserts done.
  - Response: rsp_err=1, rsp_data=0 after 16 WAIT cycles; next request is accepted normally.
  - Variant: done on the timeout cycle → rsp_err=0 with the model's result.
- Reset in WAIT:
  - Stimulus: pulse rst_n low while the FSM is in WAIT.
  - Response: all outputs 0 asynchronously; no rsp_valid; with reqs 1 and 0 both pending afterwards, requester 0 is granted first.
- Stray done:
  - Stimulus: mul_done pulsed in IDLE and in RESP.
  - Response: no state change; rsp_data unchanged.
